// File: rtl/psram_arbiter.sv
// ---------------------------------------------------------------------------
// psram_arbiter
//
// Single-port arbiter and access sequencer for the shared asynchronous
// PSDRAM. Two requesters share the device:
//   * display line-fetch engine : read-only, high priority
//   * host loader port          : read/write, low priority
// The arbiter owns every PSDRAM strobe, the address bus and the write data
// bus. Requesters see a level req / one-cycle ack handshake only. A
// starvation counter forces a host grant after STARVE_LIMIT consecutive
// display grants while the host is waiting.
//
// Access timeline (cycle 0 = IDLE cycle that makes the grant):
//   cycles 1..ACCESS_CYCLES         strobes active
//   cycle  ACCESS_CYCLES+1          strobes inactive, ack pulse, rdata valid
//   RECOVER_CYCLES cycles           all strobes inactive
//
// Ports:
//   clk_25Mhz       in   system pixel clock, rising edge
//   reset           in   asynchronous, active-high
//   disp_req/addr   in   display read request (level) and word address
//   disp_ack        out  one-cycle completion pulse
//   disp_rdata      out  display read data, held until the next display read
//   host_req/we     in   host request (level) and direction (1 = write)
//   host_addr       in   host word address
//   host_wdata/be   in   host write data and byte enables ([0] = low byte)
//   host_ack        out  one-cycle completion pulse
//   host_rdata      out  host read data, valid with host_ack on reads
//   busy            out  high whenever the sequencer is not IDLE
//   MemAdr          out  PSDRAM word address
//   MemDataOut/Oe   out  PSDRAM write data and its tristate enable
//   MemDataIn       in   PSDRAM read data
//   MemOE, MemWR, RamCE, RamLB, RamUB  out  PSDRAM strobes, active-low
// ---------------------------------------------------------------------------
module psram_arbiter #(
  parameter int unsigned ACCESS_CYCLES  = 3,  // 2..15
  parameter int unsigned RECOVER_CYCLES = 1,  // 1..15
  parameter int unsigned STARVE_LIMIT   = 8   // 1..255
) (
  input  logic        clk_25Mhz,
  input  logic        reset,
  // display line-fetch port
  input  logic        disp_req,
  input  logic [22:0] disp_addr,
  output logic        disp_ack,
  output logic [15:0] disp_rdata,
  // host loader port
  input  logic        host_req,
  input  logic        host_we,
  input  logic [22:0] host_addr,
  input  logic [15:0] host_wdata,
  input  logic [1:0]  host_be,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        busy,
  // PSDRAM side
  output logic [22:0] MemAdr,
  output logic [15:0] MemDataOut,
  output logic        MemDataOe,
  input  logic [15:0] MemDataIn,
  output logic        MemOE,
  output logic        MemWR,
  output logic        RamCE,
  output logic        RamLB,
  output logic        RamUB
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [3:0] ACC_LOAD   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] REC_LOAD   = 4'(RECOVER_CYCLES - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t      r_state;
  logic [3:0]  r_cnt;          // shared ACCESS / RECOVER down-counter
  logic [7:0]  r_starve;       // consecutive display grants with host waiting
  logic        r_gnt_host;     // current access belongs to the host
  logic        r_gnt_write;    // current access is a write
  logic [22:0] r_mem_adr;
  logic [15:0] r_mem_dout;
  logic        r_mem_doe;
  logic        r_mem_oe_n;
  logic        r_mem_wr_n;
  logic        r_ram_ce_n;
  logic        r_ram_lb_n;
  logic        r_ram_ub_n;
  logic        r_disp_ack;
  logic        r_host_ack;
  logic [15:0] r_disp_rdata;
  logic [15:0] r_host_rdata;
  logic        r_busy;

  // -------------------------------------------------------------------------
  // Next-value wires
  // -------------------------------------------------------------------------
  state_t      w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [7:0]  w_starve_nxt;
  logic        w_gnt_host_nxt;
  logic        w_gnt_write_nxt;
  logic [22:0] w_mem_adr_nxt;
  logic [15:0] w_mem_dout_nxt;
  logic        w_mem_doe_nxt;
  logic        w_mem_oe_n_nxt;
  logic        w_mem_wr_n_nxt;
  logic        w_ram_ce_n_nxt;
  logic        w_ram_lb_n_nxt;
  logic        w_ram_ub_n_nxt;
  logic        w_disp_ack_nxt;
  logic        w_host_ack_nxt;
  logic [15:0] w_disp_rdata_nxt;
  logic [15:0] w_host_rdata_nxt;
  logic        w_busy_nxt;

  // Grant decision, only meaningful in IDLE. The host wins a contested
  // grant only once the display has used up its starvation allowance.
  logic w_in_idle;
  logic w_host_forced;
  logic w_grant_disp;
  logic w_grant_host;
  logic w_grant_write;
  logic w_last_access;

  assign w_in_idle     = (r_state == IDLE);
  assign w_host_forced = host_req && (r_starve == STARVE_MAX);
  assign w_grant_disp  = w_in_idle && disp_req && !w_host_forced;
  assign w_grant_host  = w_in_idle && host_req && !w_grant_disp;
  assign w_grant_write = w_grant_host && host_we;  // display grants always read
  assign w_last_access = (r_state == ACCESS) && (r_cnt == 4'd0);

  // -------------------------------------------------------------------------
  // Process 1: state and output registers
  // -------------------------------------------------------------------------
  // NOTE: every clocked assignment is non-blocking so all registers update
  // together from the values computed in the combinational processes.
  always_ff @(posedge clk_25Mhz or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_starve     <= 8'd0;
      r_gnt_host   <= 1'b0;
      r_gnt_write  <= 1'b0;
      r_mem_adr    <= 23'd0;
      r_mem_dout   <= 16'd0;
      r_mem_doe    <= 1'b0;
      r_mem_oe_n   <= 1'b1;
      r_mem_wr_n   <= 1'b1;
      r_ram_ce_n   <= 1'b1;
      r_ram_lb_n   <= 1'b1;
      r_ram_ub_n   <= 1'b1;
      r_disp_ack   <= 1'b0;
      r_host_ack   <= 1'b0;
      r_disp_rdata <= 16'd0;
      r_host_rdata <= 16'd0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_starve     <= w_starve_nxt;
      r_gnt_host   <= w_gnt_host_nxt;
      r_gnt_write  <= w_gnt_write_nxt;
      r_mem_adr    <= w_mem_adr_nxt;
      r_mem_dout   <= w_mem_dout_nxt;
      r_mem_doe    <= w_mem_doe_nxt;
      r_mem_oe_n   <= w_mem_oe_n_nxt;
      r_mem_wr_n   <= w_mem_wr_n_nxt;
      r_ram_ce_n   <= w_ram_ce_n_nxt;
      r_ram_lb_n   <= w_ram_lb_n_nxt;
      r_ram_ub_n   <= w_ram_ub_n_nxt;
      r_disp_ack   <= w_disp_ack_nxt;
      r_host_ack   <= w_host_ack_nxt;
      r_disp_rdata <= w_disp_rdata_nxt;
      r_host_rdata <= w_host_rdata_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: next-state logic and the shared phase counter
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_grant_disp || w_grant_host) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = ACC_LOAD;
        end
      end
      ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RECOVER;
          w_cnt_nxt   = REC_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RECOVER: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Process 3: next values of the registered outputs and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    w_starve_nxt     = r_starve;
    w_gnt_host_nxt   = r_gnt_host;
    w_gnt_write_nxt  = r_gnt_write;
    w_mem_adr_nxt    = r_mem_adr;
    w_mem_dout_nxt   = r_mem_dout;
    w_mem_doe_nxt    = r_mem_doe;
    w_mem_oe_n_nxt   = r_mem_oe_n;
    w_mem_wr_n_nxt   = r_mem_wr_n;
    w_ram_ce_n_nxt   = r_ram_ce_n;
    w_ram_lb_n_nxt   = r_ram_lb_n;
    w_ram_ub_n_nxt   = r_ram_ub_n;
    w_disp_ack_nxt   = 1'b0;
    w_host_ack_nxt   = 1'b0;
    w_disp_rdata_nxt = r_disp_rdata;
    w_host_rdata_nxt = r_host_rdata;
    w_busy_nxt       = (w_state_nxt != IDLE);

    unique case (r_state)
      IDLE: begin
        // Starvation counter: cleared whenever the host is served or not
        // waiting, otherwise counts display grants up to the limit.
        if (w_grant_host || !host_req) begin
          w_starve_nxt = 8'd0;
        end else if (w_grant_disp && (r_starve != STARVE_MAX)) begin
          w_starve_nxt = r_starve + 8'd1;
        end

        if (w_grant_disp || w_grant_host) begin
          w_gnt_host_nxt  = w_grant_host;
          w_gnt_write_nxt = w_grant_write;
          w_mem_adr_nxt   = w_grant_host ? host_addr : disp_addr;
          w_ram_ce_n_nxt  = 1'b0;
          if (w_grant_write) begin
            w_mem_wr_n_nxt = 1'b0;
            w_ram_lb_n_nxt = ~host_be[0];
            w_ram_ub_n_nxt = ~host_be[1];
            w_mem_dout_nxt = host_wdata;
            w_mem_doe_nxt  = 1'b1;
          end else begin
            w_mem_oe_n_nxt = 1'b0;
            w_ram_lb_n_nxt = 1'b0;
            w_ram_ub_n_nxt = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (w_last_access) begin
          if (!r_gnt_write) begin
            if (r_gnt_host) w_host_rdata_nxt = MemDataIn;
            else            w_disp_rdata_nxt = MemDataIn;
          end
          w_host_ack_nxt = r_gnt_host;
          w_disp_ack_nxt = !r_gnt_host;
          w_ram_ce_n_nxt = 1'b1;
          w_mem_oe_n_nxt = 1'b1;
          w_mem_wr_n_nxt = 1'b1;
          w_ram_lb_n_nxt = 1'b1;
          w_ram_ub_n_nxt = 1'b1;
          // MemDataOe is left alone so write data stays driven through the
          // first RECOVER cycle as hold time after MemWR rises.
        end
      end
      RECOVER: begin
        w_mem_doe_nxt = 1'b0;
      end
      default: begin
        w_ram_ce_n_nxt = 1'b1;
        w_mem_oe_n_nxt = 1'b1;
        w_mem_wr_n_nxt = 1'b1;
        w_ram_lb_n_nxt = 1'b1;
        w_ram_ub_n_nxt = 1'b1;
        w_mem_doe_nxt  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign MemAdr     = r_mem_adr;
  assign MemDataOut = r_mem_dout;
  assign MemDataOe  = r_mem_doe;
  assign MemOE      = r_mem_oe_n;
  assign MemWR      = r_mem_wr_n;
  assign RamCE      = r_ram_ce_n;
  assign RamLB      = r_ram_lb_n;
  assign RamUB      = r_ram_ub_n;
  assign disp_ack   = r_disp_ack;
  assign host_ack   = r_host_ack;
  assign disp_rdata = r_disp_rdata;
  assign host_rdata = r_host_rdata;
  assign busy       = r_busy;

endmodule

// File: tb/tb_psram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_psram_arbiter
//
// Self-checking bench for psram_arbiter with default parameters
// (ACCESS_CYCLES = 3, RECOVER_CYCLES = 1, STARVE_LIMIT = 8).
// A small word-addressed PSDRAM model (1024 words, low address bits) answers
// reads combinationally and applies byte-masked writes on the clock edge.
// Single transactions come from a vector table; starvation, late request and
// reset-abort behaviour are hand-written sequences. A protocol monitor runs
// for the whole simulation.
// ---------------------------------------------------------------------------
module tb_psram_arbiter;

  logic        clk_25Mhz = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [22:0] disp_addr;
  logic        disp_ack;
  logic [15:0] disp_rdata;
  logic        host_req;
  logic        host_we;
  logic [22:0] host_addr;
  logic [15:0] host_wdata;
  logic [1:0]  host_be;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        busy;
  logic [22:0] MemAdr;
  logic [15:0] MemDataOut;
  logic        MemDataOe;
  logic [15:0] MemDataIn;
  logic        MemOE;
  logic        MemWR;
  logic        RamCE;
  logic        RamLB;
  logic        RamUB;

  always #20 clk_25Mhz = ~clk_25Mhz;

  psram_arbiter dut (
    .clk_25Mhz  (clk_25Mhz),
    .reset      (reset),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_ack   (disp_ack),
    .disp_rdata (disp_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_be    (host_be),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .busy       (busy),
    .MemAdr     (MemAdr),
    .MemDataOut (MemDataOut),
    .MemDataOe  (MemDataOe),
    .MemDataIn  (MemDataIn),
    .MemOE      (MemOE),
    .MemWR      (MemWR),
    .RamCE      (RamCE),
    .RamLB      (RamLB),
    .RamUB      (RamUB)
  );

  // ---------------------------------------------------------------- memory
  logic [15:0] mem [1024] = '{default: 16'h0000};
  logic        pre_en  = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [15:0] pre_val = '0;

  assign MemDataIn = (!RamCE && !MemOE) ? mem[MemAdr[9:0]] : 16'h0000;

  always @(posedge clk_25Mhz) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (!RamCE && !MemWR) begin
      if (!RamLB) mem[MemAdr[9:0]][7:0]  <= MemDataOut[7:0];
      if (!RamUB) mem[MemAdr[9:0]][15:8] <= MemDataOut[15:8];
    end
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Protocol monitor: strobe exclusivity plus grant / ack bookkeeping.
  int   n_grants = 0;
  int   n_acks   = 0;
  logic prev_ce  = 1'b1;

  always @(negedge clk_25Mhz) begin
    check("proto_oe_wr_exclusive", 32'(MemOE | MemWR), 32'd1);
    check("proto_doe_vs_oe", 32'(!(MemDataOe && !MemOE)), 32'd1);
    check("proto_single_ack", 32'(!(disp_ack && host_ack)), 32'd1);
    if (!RamCE && prev_ce) n_grants++;
    if (disp_ack || host_ack) n_acks++;
    prev_ce = RamCE;
  end

  // Strobe snapshot order: {RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOe}
  function automatic logic [5:0] strobes();
    return {RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOe};
  endfunction

  typedef struct {
    logic        is_host;
    logic        we;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] preload;
    logic [5:0]  exp_strb;   // strobes in cycles 1..3
    logic [15:0] exp_rdata;  // checked on reads only
    logic [15:0] exp_mem;    // memory word after the access
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    int last;
    int k;
    int aborted;
    logic ack_seen;
    logic busy_seen;

    //           host we  addr        wdata     be     preload   strobes    rdata     mem
    vecs[0] = '{1'b0, 1'b0, 23'h000436, 16'h0000, 2'b00, 16'hA55A, 6'b001000, 16'hA55A, 16'hA55A};
    vecs[1] = '{1'b1, 1'b1, 23'h000100, 16'h1234, 2'b01, 16'hFFFF, 6'b010011, 16'h0000, 16'hFF34};
    vecs[2] = '{1'b1, 1'b1, 23'h000101, 16'hBEEF, 2'b10, 16'h0000, 6'b010101, 16'h0000, 16'hBE00};
    vecs[3] = '{1'b1, 1'b1, 23'h000102, 16'hCAFE, 2'b11, 16'h1111, 6'b010001, 16'h0000, 16'hCAFE};
    vecs[4] = '{1'b1, 1'b0, 23'h000200, 16'h0000, 2'b00, 16'h5A5A, 6'b001000, 16'h5A5A, 16'h5A5A};
    vecs[5] = '{1'b0, 1'b1, 23'h7FFFFF, 16'h0000, 2'b00, 16'h0F0F, 6'b001000, 16'h0F0F, 16'h0F0F};
    vecs[6] = '{1'b1, 1'b1, 23'h000303, 16'h9999, 2'b00, 16'h7777, 6'b010111, 16'h0000, 16'h7777};
    vecs[7] = '{1'b1, 1'b0, 23'h7FFFFE, 16'h0000, 2'b00, 16'h8001, 6'b001000, 16'h8001, 16'h8001};

    aborted    = 0;
    reset      = 1'b1;
    disp_req   = 1'b0;
    disp_addr  = '0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    host_be    = '0;

    // ------------------------------------------------ reset values
    @(negedge clk_25Mhz);
    check("rst_strobes", 32'(strobes()), 32'(6'b111110));
    check("rst_memadr", 32'(MemAdr), 32'd0);
    check("rst_dataout", 32'(MemDataOut), 32'd0);
    check("rst_acks_busy", 32'({disp_ack, host_ack, busy}), 32'd0);
    check("rst_rdata", 32'({disp_rdata, host_rdata}), 32'd0);
    reset = 1'b0;
    @(negedge clk_25Mhz);
    check("post_rst_idle", 32'({busy, RamCE}), 32'(2'b01));

    // ------------------------------------------------ vector table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_25Mhz);
      pre_en     = 1'b1;
      pre_idx    = vecs[i].addr[9:0];
      pre_val    = vecs[i].preload;
      host_we    = vecs[i].we;
      host_wdata = vecs[i].wdata;
      host_be    = vecs[i].be;
      if (vecs[i].is_host) begin
        host_addr = vecs[i].addr;
        host_req  = 1'b1;
      end else begin
        disp_addr = vecs[i].addr;
        disp_req  = 1'b1;
      end
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk_25Mhz);
        pre_en = 1'b0;
        check($sformatf("v%0d_c%0d_strobes", i, c), 32'(strobes()), 32'(vecs[i].exp_strb));
        check($sformatf("v%0d_c%0d_memadr", i, c), 32'(MemAdr), 32'(vecs[i].addr));
        check($sformatf("v%0d_c%0d_busy_acks", i, c), 32'({busy, disp_ack, host_ack}), 32'(3'b100));
        if (vecs[i].is_host && vecs[i].we)
          check($sformatf("v%0d_c%0d_dataout", i, c), 32'(MemDataOut), 32'(vecs[i].wdata));
      end
      @(negedge clk_25Mhz);
      check($sformatf("v%0d_c4_strobes", i), 32'(strobes()),
            32'({5'b11111, vecs[i].is_host & vecs[i].we}));
      check($sformatf("v%0d_c4_acks", i), 32'({disp_ack, host_ack}),
            32'({!vecs[i].is_host, vecs[i].is_host}));
      if (!(vecs[i].is_host && vecs[i].we))
        check($sformatf("v%0d_c4_rdata", i),
              32'(vecs[i].is_host ? host_rdata : disp_rdata), 32'(vecs[i].exp_rdata));
      disp_req = 1'b0;
      host_req = 1'b0;
      @(negedge clk_25Mhz);
      check($sformatf("v%0d_c5_idle", i), 32'({busy, disp_ack, host_ack}), 32'd0);
      check($sformatf("v%0d_c5_strobes", i), 32'(strobes()), 32'(6'b111110));
      check($sformatf("v%0d_mem", i), 32'(mem[vecs[i].addr[9:0]]), 32'(vecs[i].exp_mem));
    end

    // ------------------------------------------------ starvation guard
    @(negedge clk_25Mhz);
    disp_addr = 23'h000010;
    host_addr = 23'h000020;
    host_we   = 1'b0;
    disp_req  = 1'b1;
    host_req  = 1'b1;
    cyc  = 0;
    last = 0;
    k    = 0;
    while (k < 18 && cyc < 200) begin
      @(negedge clk_25Mhz);
      cyc++;
      if (disp_ack || host_ack) begin
        check($sformatf("starve_gap_%0d", k), 32'(cyc - last), (k == 0) ? 32'd4 : 32'd5);
        check($sformatf("starve_who_%0d", k), 32'({disp_ack, host_ack}),
              (k % 9 == 8) ? 32'(2'b01) : 32'(2'b10));
        last = cyc;
        k++;
        if (k == 18) begin
          disp_req = 1'b0;
          host_req = 1'b0;
        end
      end
    end
    check("starve_ack_count", 32'(k), 32'd18);
    disp_req = 1'b0;
    host_req = 1'b0;
    repeat (2) @(negedge clk_25Mhz);
    check("starve_end_idle", 32'(busy), 32'd0);

    // ------------------------------------------------ late display request
    @(negedge clk_25Mhz);
    host_addr = 23'h000200;   // still holds 0x5A5A
    host_we   = 1'b0;
    host_req  = 1'b1;
    @(negedge clk_25Mhz);     // cycle 1
    @(negedge clk_25Mhz);     // cycle 2
    disp_addr = 23'h000436;   // still holds 0xA55A
    disp_req  = 1'b1;
    @(negedge clk_25Mhz);     // cycle 3
    check("late_c3_memadr", 32'(MemAdr), 32'h000200);
    @(negedge clk_25Mhz);     // cycle 4
    check("late_c4_acks", 32'({disp_ack, host_ack}), 32'(2'b01));
    check("late_c4_host_rdata", 32'(host_rdata), 32'h5A5A);
    host_req = 1'b0;
    @(negedge clk_25Mhz);     // cycle 5: IDLE, display granted here
    check("late_c5_idle", 32'({busy, RamCE}), 32'(2'b01));
    @(negedge clk_25Mhz);     // cycle 6
    check("late_c6_disp_strobes", 32'(strobes()), 32'(6'b001000));
    check("late_c6_memadr", 32'(MemAdr), 32'h000436);
    repeat (3) @(negedge clk_25Mhz);  // cycle 9
    check("late_c9_acks", 32'({disp_ack, host_ack}), 32'(2'b10));
    check("late_c9_disp_rdata", 32'(disp_rdata), 32'hA55A);
    disp_req = 1'b0;
    @(negedge clk_25Mhz);
    check("late_c10_idle", 32'(busy), 32'd0);

    // ------------------------------------------------ reset mid-write
    @(negedge clk_25Mhz);
    host_addr  = 23'h000050;
    host_wdata = 16'hDEAD;
    host_be    = 2'b11;
    host_we    = 1'b1;
    host_req   = 1'b1;
    @(negedge clk_25Mhz);     // cycle 1
    check("rstmid_c1_write", 32'({MemWR, RamCE, MemDataOe}), 32'(3'b001));
    @(negedge clk_25Mhz);     // cycle 2
    reset = 1'b1;
    aborted++;
    #1;
    check("rstmid_strobes", 32'({MemWR, RamCE, MemDataOe}), 32'(3'b110));
    check("rstmid_busy_ack", 32'({busy, host_ack}), 32'd0);
    host_req = 1'b0;
    host_we  = 1'b0;
    @(negedge clk_25Mhz);
    @(negedge clk_25Mhz);
    reset = 1'b0;
    ack_seen  = 1'b0;
    busy_seen = 1'b0;
    repeat (6) begin
      @(negedge clk_25Mhz);
      ack_seen  = ack_seen | host_ack | disp_ack;
      busy_seen = busy_seen | busy;
    end
    check("rstmid_no_ack", 32'(ack_seen), 32'd0);
    check("rstmid_idle", 32'({busy_seen, RamCE}), 32'(2'b01));

    // ------------------------------------------------ one ack per grant
    check("ack_per_grant", 32'(n_acks), 32'(n_grants - aborted));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
